usb_boot_supervisor: RTL and testbench
======================================

Name: usb_boot_supervisor

Overview:
Parametrised successor to the bootloader's inline LED-breathe and host-presence logic, packaged as one reusable supervisor. It drives NUM_LEDS indicator channels with per-channel modes (off/on/breathe/blink) from a shared PWM breathing engine. It tracks USB host presence from SOF pulses and owns a boot-handoff FSM with a programmable post-request delay, so the final ACK can leave the wire before reconfiguration. It sits beside usb_fs_pe and the control endpoint in the bootloader top level.

Parameters:
CLK_FREQ_HZ, 48000000, clock frequency; CLK_FREQ_HZ/1000000 must be an integer >= 2
NUM_LEDS, 1, number of LED channels, 1..8
PWM_BITS, 8, PWM/brightness resolution; MAX = 2^PWM_BITS-1
STEP_US, 1000, microseconds per breathing step
HOST_TIMEOUT_CYCLES, 33554432, clocks without an SOF before the host is declared absent
BOOT_DELAY_CYCLES, 48000, clocks from boot_req acceptance to boot assertion; 0 allowed

Ports:
clk_48mhz  in  1  system clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
sof_valid  in  1  single-cycle pulse per received SOF, from usb_fs_pe
boot_req  in  1  single-cycle request from the control endpoint to boot the user image
led_mode  in  2*NUM_LEDS  per-channel mode, 2 bits per channel: 0 OFF, 1 ON, 2 BREATHE, 3 BLINK
led  out  NUM_LEDS  LED drive, one bit per channel
host_present  out  1  high after an SOF is seen, until timeout
boot  out  1  registered and sticky; high means load the user config
state  out  2  FSM state, for debug

Behaviour:
- Reset values: led=0, host_present=0, boot=0, state=ACTIVE, all counters 0, breathe level=0, direction=up.
- us tick: a divider counts 0..CLK_FREQ_HZ/1e6-1 and pulses on wrap, giving exactly one pulse per CLK_FREQ_HZ/1e6 clocks.
- Step tick: a counter of us ticks pulses on the STEP_US-th tick, then wraps to 0.
- On each step tick:
  - Direction up: if level==MAX, set direction=down; else level+1.
  - Direction down: if level==0, set direction=up; else level-1.
  - Each extreme is therefore held for one extra step.
- PWM: pwm_cnt is a free-running PWM_BITS counter, reset to 0. The breathe output is (level > pwm_cnt); level 0 gives constant 0.
- Per-channel output (registered, 1-cycle latency from led_mode):
  - OFF = 0.
  - ON = 1.
  - BREATHE = breathe output.
  - BLINK = direction flag (1 while counting up).
- Host timer (width clog2(HOST_TIMEOUT_CYCLES+1)):
  - sof_valid clears the timer and sets host_present.
  - Otherwise the timer increments, saturating at HOST_TIMEOUT_CYCLES.
  - timeout = (timer==HOST_TIMEOUT_CYCLES). Timeout clears host_present.
  - A sof_valid in the same cycle as timeout wins: timer cleared, no timeout acted on.
- FSM states: ACTIVE=0, DELAY=1, BOOT=2.
  - ACTIVE: timeout → BOOT. Else boot_req with BOOT_DELAY_CYCLES==0 → BOOT. Else boot_req → DELAY, loading dly_cnt=BOOT_DELAY_CYCLES-1.
  - DELAY: timeout → BOOT immediately. Else dly_cnt==0 → BOOT. Else dly_cnt-1. Further boot_req pulses are ignored.
  - BOOT: terminal until reset. boot=1, all led forced 0, boot_req and sof_valid are don't-care for the FSM.
- Latency:
  - boot_req sampled at edge N makes boot high after edge N+1+BOOT_DELAY_CYCLES.
  - A timeout first true after edge M makes boot high after edge M+1.
- A simultaneous boot_req and timeout in ACTIVE → BOOT (timeout priority).
- Reset mid-operation, in any state, returns every register to its reset value on that edge. boot deasserts.

Decomposition:
- Package usb_boot_pkg holds the FSM state encoding (ACTIVE/DELAY/BOOT) and the LED mode constants (LED_OFF/ON/BREATHE/BLINK).
- Sub-module led_breathe_pwm (params CLK_FREQ_HZ, PWM_BITS, STEP_US) contains the us divider, step counter, level/direction and pwm_cnt. It outputs breathe_out and dir_up.
- The top contains the host timer, FSM, and per-channel muxing/forcing.

Test Plan:
All tests use CLK_FREQ_HZ=4000000, STEP_US=2, PWM_BITS=3, NUM_LEDS=2, HOST_TIMEOUT_CYCLES=100, BOOT_DELAY_CYCLES=10.
1. No SOF after reset release → boot rises exactly 101 clocks after the release edge; host_present stays 0; state=2.
2. sof_valid every 50 clocks for 1000 clocks → host_present=1 from the cycle after the first SOF; boot stays 0. Stop SOFs → host_present falls 100 clocks after the last SOF; boot follows 1 clock later.
3. SOF every 50 clocks, boot_req pulse at edge N → state=1 at N+1, boot=1 after edge N+11. A second boot_req at N+5 has no effect. Both leds read 0 once in BOOT.
4. led_mode={BREATHE,ON} → led[0]=1 constant. Level steps every 8 clocks 0→7, holds, 7→0. Duty of led[1] per 8-clock PWM window equals the level. At level 0, led[1] is never high.
5. led_mode={BLINK,OFF} → led[1] toggles after each extreme hold (period 128 clocks); led[0]=0.
6. Reset asserted during DELAY with dly_cnt=4 → the next cycle shows state=0, boot=0, led=0. A fresh boot_req again takes 11 clocks.

Source files
------------

// File: rtl/usb_boot_pkg.sv
// usb_boot_pkg: shared FSM state encoding and LED mode codes for the boot supervisor
package usb_boot_pkg;
   typedef enum logic [1:0] {ACTIVE = 2'd0, DELAY = 2'd1, BOOT = 2'd2} state_t;
   localparam logic [1:0] LED_OFF = 2'd0;
   localparam logic [1:0] LED_ON = 2'd1;
   localparam logic [1:0] LED_BREATHE = 2'd2;
   localparam logic [1:0] LED_BLINK = 2'd3;
endpackage

// File: rtl/led_breathe_pwm.sv
// led_breathe_pwm: microsecond divider, breathing level ramp and PWM comparator
module led_breathe_pwm #(
   parameter int CLK_FREQ_HZ = 48000000,
   parameter int PWM_BITS = 8,
   parameter int STEP_US = 1000
) (
   input logic clk_48mhz,
   input logic reset,
   output logic breathe_out,
   output logic dir_up
);
   localparam int DIV = CLK_FREQ_HZ / 1000000;
   localparam int UW = $clog2(DIV);
   localparam int SW = STEP_US > 1 ? $clog2(STEP_US) : 1;
   localparam logic [PWM_BITS-1:0] MAX = '1;
   logic [UW-1:0] us_cnt;
   logic [SW-1:0] step_cnt;
   logic [PWM_BITS-1:0] level, pwm_cnt;
   logic us_tick, step_tick;
   assign us_tick = us_cnt == UW'(DIV - 1);
   assign step_tick = us_tick && step_cnt == SW'(STEP_US - 1);
   assign breathe_out = level > pwm_cnt;
   // each extreme holds for one extra step while the direction flips
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         us_cnt <= '0;
         step_cnt <= '0;
         level <= '0;
         pwm_cnt <= '0;
         dir_up <= 1'b1;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
         if (us_tick) step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
         if (step_tick) begin
            if (dir_up) begin
               if (level == MAX) dir_up <= 1'b0;
               else level <= level + 1'b1;
            end else begin
               if (level == '0) dir_up <= 1'b1;
               else level <= level - 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/usb_boot_supervisor.sv
// usb_boot_supervisor: LED mode muxing, SOF-based host presence and delayed boot handoff
module usb_boot_supervisor
   import usb_boot_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 48000000,
   parameter int NUM_LEDS = 1,
   parameter int PWM_BITS = 8,
   parameter int STEP_US = 1000,
   parameter int HOST_TIMEOUT_CYCLES = 33554432,
   parameter int BOOT_DELAY_CYCLES = 48000
) (
   input logic clk_48mhz,
   input logic reset,
   input logic sof_valid,
   input logic boot_req,
   input logic [2*NUM_LEDS-1:0] led_mode,
   output logic [NUM_LEDS-1:0] led,
   output logic host_present,
   output logic boot,
   output logic [1:0] state
);
   localparam int TW = $clog2(HOST_TIMEOUT_CYCLES + 1);
   localparam int DW = BOOT_DELAY_CYCLES > 1 ? $clog2(BOOT_DELAY_CYCLES) : 1;
   localparam logic [TW-1:0] T_MAX = TW'(HOST_TIMEOUT_CYCLES);
   localparam logic [DW-1:0] DLY_LOAD = DW'(BOOT_DELAY_CYCLES > 0 ? BOOT_DELAY_CYCLES - 1 : 0);
   state_t st, st_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [DW-1:0] dly_cnt;
   logic [NUM_LEDS-1:0] led_nxt;
   logic req_q, timeout, breathe, dir_up;
   led_breathe_pwm #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .PWM_BITS(PWM_BITS), .STEP_US(STEP_US)) u_pwm (
      .clk_48mhz(clk_48mhz),
      .reset(reset),
      .breathe_out(breathe),
      .dir_up(dir_up)
   );
   assign state = st;
   assign timer_nxt = sof_valid ? '0 : timer == T_MAX ? T_MAX : timer + 1'b1;
   // an SOF arriving on the timeout cycle rescues the host
   assign timeout = !sof_valid && timer == T_MAX;
   // boot_req is registered first, so acceptance happens one edge after sampling
   always_comb begin
      st_nxt = st;
      if (st == BOOT || timeout) st_nxt = BOOT;
      else if (st == DELAY) st_nxt = dly_cnt == '0 ? BOOT : DELAY;
      else if (req_q) st_nxt = BOOT_DELAY_CYCLES == 0 ? BOOT : DELAY;
   end
   always_comb begin
      led_nxt = '0;
      for (int i = 0; i < NUM_LEDS; i++)
         led_nxt[i] = led_mode[2*i+:2] == LED_ON ? 1'b1 :
                      led_mode[2*i+:2] == LED_BREATHE ? breathe :
                      led_mode[2*i+:2] == LED_BLINK ? dir_up : 1'b0;
   end
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         st <= ACTIVE;
         timer <= '0;
         dly_cnt <= '0;
         req_q <= 1'b0;
         host_present <= 1'b0;
         boot <= 1'b0;
         led <= '0;
      end else begin
         st <= st_nxt;
         timer <= timer_nxt;
         req_q <= boot_req;
         host_present <= sof_valid | (host_present & (timer_nxt != T_MAX));
         dly_cnt <= st == DELAY ? dly_cnt - 1'b1 : DLY_LOAD;
         boot <= st_nxt == BOOT;
         led <= st_nxt == BOOT ? '0 : led_nxt;
      end
   end
endmodule

// File: tb/tb_usb_boot_supervisor.sv
// tb_usb_boot_supervisor: directed and random stimulus against a deadline-based reference model
module tb_usb_boot_supervisor;
   localparam logic [3:0] M_BREATHE_ON = 4'b1001;
   localparam logic [3:0] M_BLINK_OFF = 4'b1100;
   logic clk = 1'b0, rst = 1'b1, sof = 1'b0, req = 1'b0;
   logic [3:0] mode = '0;
   logic [1:0] led, state;
   logic host, boot;
   int total = 0, bad = 0;
   int e = 0, last_sof = 0, r_acc = 0;
   bit seen = 0, m_boot = 0, m_pend = 0, req_prev = 0;
   usb_boot_supervisor #(
      .CLK_FREQ_HZ(4000000), .NUM_LEDS(2), .PWM_BITS(3), .STEP_US(2),
      .HOST_TIMEOUT_CYCLES(100), .BOOT_DELAY_CYCLES(10)
   ) dut (
      .clk_48mhz(clk), .reset(rst), .sof_valid(sof), .boot_req(req),
      .led_mode(mode), .led(led), .host_present(host), .boot(boot), .state(state)
   );
   always #5 clk = ~clk;
   // breathing waveform: 16-step triangle of 8-clock steps; t counts clocks since reset
   function automatic logic mode_led(logic [1:0] m, int t);
      int p = (t / 8) % 16;
      int lvl = p < 8 ? p : 15 - p;
      return m == 2'd1 ? 1'b1 : m == 2'd2 ? logic'(lvl > t % 8) : m == 2'd3 ? logic'(p < 8) : 1'b0;
   endfunction
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick(bit r, bit s, bit q, logic [3:0] md);
      logic [1:0] exp_led;
      rst = r; sof = s; req = q; mode = md;
      @(posedge clk);
      #1;
      if (r) begin
         e = 0; last_sof = 0; seen = 0; m_boot = 0; m_pend = 0; req_prev = 0;
      end else begin
         e++;
         if (!m_boot) begin
            if (!s && e - 1 - last_sof >= 100) m_boot = 1;
            else if (m_pend) begin
               if (e >= r_acc + 11) m_boot = 1;
            end else if (req_prev) begin
               m_pend = 1;
               r_acc = e - 1;
            end
         end
         if (s) begin
            last_sof = e;
            seen = 1;
         end
         req_prev = q;
      end
      exp_led = (m_boot || e == 0) ? 2'b00 : {mode_led(md[3:2], e - 1), mode_led(md[1:0], e - 1)};
      chk("led", led, exp_led);
      chk("host_present", host, seen && e - last_sof < 100);
      chk("boot", boot, m_boot);
      chk("state", state, m_boot ? 2 : m_pend ? 1 : 0);
   endtask
   initial begin
      int rise, fall, n;
      repeat (3) tick(1, 0, 0, 4'($urandom));
      // no host at all: boot from timeout
      rise = 0;
      for (int i = 0; i < 110; i++) begin
         tick(0, 0, 0, 4'($urandom));
         if (boot && rise == 0) rise = e;
      end
      chk("t1_boot_rise", rise, 101);
      // host alive, then SOFs stop
      repeat (2) tick(1, 0, 0, 4'($urandom));
      for (int i = 0; i < 1000; i++) tick(0, i % 50 == 0, 0, 4'($urandom));
      rise = 0; fall = 0;
      for (int i = 0; i < 110; i++) begin
         tick(0, 0, 0, 4'($urandom));
         if (!host && fall == 0) fall = e;
         if (boot && rise == 0) rise = e;
      end
      chk("t2_host_fall", fall, 1051);
      chk("t2_boot_rise", rise, 1052);
      // boot request with a duplicate during the delay
      repeat (2) tick(1, 0, 0, 4'b0000);
      for (int i = 0; i < 20; i++) tick(0, i % 50 == 0, 0, M_BREATHE_ON);
      tick(0, 0, 1, M_BREATHE_ON);
      n = e;
      rise = 0;
      for (int i = 1; i < 20; i++) begin
         tick(0, 0, i == 5, M_BREATHE_ON);
         if (i == 1) chk("t3_delay_state", state, 1);
         if (boot && rise == 0) rise = e;
      end
      chk("t3_boot_rise", rise - n, 11);
      chk("t3_led_off", led, 0);
      // breathe/on then blink/off over two full triangles each
      repeat (2) tick(1, 0, 0, M_BREATHE_ON);
      for (int i = 0; i < 300; i++) tick(0, i % 50 == 0, 0, M_BREATHE_ON);
      for (int i = 0; i < 300; i++) tick(0, i % 50 == 0, 0, M_BLINK_OFF);
      // reset in the middle of the delay
      repeat (2) tick(1, 0, 0, M_BREATHE_ON);
      for (int i = 0; i < 10; i++) tick(0, i == 0, 0, M_BREATHE_ON);
      tick(0, 0, 1, M_BREATHE_ON);
      repeat (6) tick(0, 0, 0, M_BREATHE_ON);
      chk("t6_pre_state", state, 1);
      tick(1, 0, 0, M_BREATHE_ON);
      chk("t6_reset_state", state, 0);
      tick(0, 1, 1, M_BLINK_OFF);
      n = e;
      rise = 0;
      for (int i = 0; i < 15; i++) begin
         tick(0, 0, 0, M_BLINK_OFF);
         if (boot && rise == 0) rise = e;
      end
      chk("t6_boot_rise", rise - n, 11);
      // random traffic with occasional resets
      repeat (2) tick(1, 0, 0, 4'($urandom));
      for (int i = 0; i < 2500; i++)
         tick($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 299) == 0, 4'($urandom));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
